// File: rtl/jt053246_objtable.sv
// ---------------------------------------------------------------------------
// jt053246_objtable
//
// Sprite-table front end of the 053246/053247 object generator.
//   * Holds the CPU-visible 8 x 8-bit register file. It decodes the sprite
//     offsets, the global configuration byte and the ROM-readback address.
//   * During vertical blank it copies the 2048-word object list from
//     external work RAM into an internal table split into even/odd words.
//   * It serves that table to the object scanner through a read-only,
//     registered port.
//
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   pxl2_cen           2x pixel clock enable; every DMA step waits for it
//   vs                 vertical sync, high during blank
//   cs, cpu_we         CPU register select / write strobe
//   cpu_addr[2:0]      CPU register address
//   cpu_dout[15:0]     CPU write data
//   cpu_dsn[1:0]       active-low byte strobes ([1] even byte, [0] odd byte)
//   cfg[7:0]           register 5: {pass[7:5], dma_en, rom_bsy, mode8, vflip, hflip}
//   xoffset, yoffset   10-bit sprite offsets
//   rmrd_addr[20:0]    ROM readback address (byte address bits 21:1)
//   dma_addr[12:0]     external RAM word address being fetched
//   dma_data[15:0]     external RAM read data, valid one pxl2_cen tick later
//   dma_bsy            a table transfer is in progress
//   scan_addr[9:0]     table read address {object[7:0], sub[1:0]}
//   scan_even/odd      object words 2*sub and 2*sub+1, one clk after scan_addr
//   st_addr, st_dout   debug readback of any register
// ---------------------------------------------------------------------------
module jt053246_objtable (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl2_cen,
    input  logic        vs,

    input  logic        cs,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_dsn,

    output logic [7:0]  cfg,
    output logic [9:0]  xoffset,
    output logic [9:0]  yoffset,
    output logic [20:0] rmrd_addr,

    output logic [12:0] dma_addr,
    input  logic [15:0] dma_data,
    output logic        dma_bsy,

    input  logic [9:0]  scan_addr,
    output logic [15:0] scan_even,
    output logic [15:0] scan_odd,

    input  logic [2:0]  st_addr,
    output logic [7:0]  st_dout
);

    typedef enum logic { IDLE, RUN } dma_state_t;

    // Number of words in the object list; the counter runs one step past
    // the last fetch so that the final word can be written.
    localparam logic [11:0] LAST_RD = 12'd2048;

    // -----------------------------------------------------------------------
    // CPU register file
    // -----------------------------------------------------------------------
    logic [7:0] mmr [8];
    logic       mode8;

    assign mode8 = mmr[5][2];

    // NOTE: sequential state is assigned with <= only, so every always_ff
    // in this file samples the values from before the edge regardless of
    // block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mmr[i] <= 8'h00;
        end else if (cs && cpu_we) begin
            if (mode8) begin
                // Byte bus: the address picks the register directly and the
                // byte strobes carry no meaning.
                mmr[cpu_addr] <= cpu_dout[7:0];
            end else begin
                // Word bus: the even register sits on the upper byte lane.
                if (!cpu_dsn[1]) mmr[{cpu_addr[2:1], 1'b0}] <= cpu_dout[15:8];
                if (!cpu_dsn[0]) mmr[{cpu_addr[2:1], 1'b1}] <= cpu_dout[7:0];
            end
        end
    end

    assign xoffset   = {mmr[0][1:0], mmr[1]};
    assign yoffset   = {mmr[2][1:0], mmr[3]};
    assign cfg       = mmr[5];
    assign rmrd_addr = {mmr[6][4:0], mmr[7], mmr[4]};
    assign st_dout   = mmr[st_addr];

    // -----------------------------------------------------------------------
    // DMA control
    // -----------------------------------------------------------------------
    dma_state_t  state, state_nx;
    logic        vs_last;     // vs as seen at the previous pxl2_cen tick
    logic [11:0] rd;          // fetch counter, 0..2048 within a transfer
    logic [10:0] wr_word;     // table word receiving the current dma_data
    logic        trigger;
    logic        last_word;
    logic        ram_we;

    assign trigger   = pxl2_cen && vs && !vs_last && cfg[4];
    assign last_word = (rd == LAST_RD);

    // The data arriving now belongs to the address issued on the previous
    // tick. At rd = 2048 the 11-bit wrap gives word 2047.
    assign wr_word = rd[10:0] - 11'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. Neither a fresh vs edge nor a dropped dma_en can
    // disturb a transfer once it has started.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = RUN;
            RUN:     if (pxl2_cen && last_word) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic. Tick rd = 0 only issues the first address; there is no
    // data to store yet.
    always_comb begin
        dma_bsy = (state == RUN);
        ram_we  = (state == RUN) && pxl2_cen && (rd != 12'd0);
    end

    // Counter, address and vs edge detector. The counter is parked at zero
    // while idle, so it is ready on the first RUN tick after a trigger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_last  <= 1'b0;
            rd       <= 12'd0;
            dma_addr <= 13'd0;
        end else if (pxl2_cen) begin
            vs_last <= vs;
            if (state == RUN) begin
                dma_addr <= {2'b00, rd[10:0]};
                rd       <= rd + 12'd1;
            end else begin
                rd <= 12'd0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Object table: two 1024 x 16 RAMs
    // -----------------------------------------------------------------------
    logic [15:0] ram_even [1024];
    logic [15:0] ram_odd  [1024];

    // NOTE: the table RAMs have no reset. Clearing them would prevent block
    // RAM inference, and a reset in mid-transfer must leave the words
    // already copied untouched.
    always_ff @(posedge clk) begin
        if (ram_we && !wr_word[0]) ram_even[wr_word[10:1]] <= dma_data;
        // Read-before-write: a collision with a DMA write returns the old word.
        scan_even <= ram_even[scan_addr];
    end

    always_ff @(posedge clk) begin
        if (ram_we && wr_word[0]) ram_odd[wr_word[10:1]] <= dma_data;
        scan_odd <= ram_odd[scan_addr];
    end

endmodule

// File: tb/tb_jt053246_objtable.sv
// ---------------------------------------------------------------------------
// Bench for jt053246_objtable.
// The reference keeps the register file as an 8-byte array, external RAM as
// a 2048-word array, and the object table as a 2048-word array that is
// updated only at whole-transfer granularity.
// ---------------------------------------------------------------------------
module tb_jt053246_objtable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl2_cen = 1'b0;
    logic        vs = 1'b0;
    logic        cs = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  cpu_dsn = 2'b11;
    logic [7:0]  cfg;
    logic [9:0]  xoffset, yoffset;
    logic [20:0] rmrd_addr;
    logic [12:0] dma_addr;
    logic [15:0] dma_data;
    logic        dma_bsy;
    logic [9:0]  scan_addr = '0;
    logic [15:0] scan_even, scan_odd;
    logic [2:0]  st_addr = '0;
    logic [7:0]  st_dout;

    always #5 clk = ~clk;

    jt053246_objtable dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl2_cen  (pxl2_cen),
        .vs        (vs),
        .cs        (cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_dsn   (cpu_dsn),
        .cfg       (cfg),
        .xoffset   (xoffset),
        .yoffset   (yoffset),
        .rmrd_addr (rmrd_addr),
        .dma_addr  (dma_addr),
        .dma_data  (dma_data),
        .dma_bsy   (dma_bsy),
        .scan_addr (scan_addr),
        .scan_even (scan_even),
        .scan_odd  (scan_odd),
        .st_addr   (st_addr),
        .st_dout   (st_dout)
    );

    // Reference state
    logic [7:0]  m       [8];
    logic [15:0] ext_ram [2048];
    logic [15:0] tbl     [2048];

    int n_cmp = 0;
    int n_err = 0;
    int bsy_ticks = 0;
    int n = 0;

    // External work RAM: combinational read, stable long before the next tick.
    assign dma_data = ext_ram[dma_addr[10:0]];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One pxl2_cen pulse followed by one idle clk. dma_bsy is sampled just
    // before the enabled edge, so bsy_ticks counts ticks spent busy.
    task automatic cen_tick();
        @(negedge clk);
        pxl2_cen = 1'b1;
        if (dma_bsy) bsy_ticks++;
        @(negedge clk);
        pxl2_cen = 1'b0;
    endtask

    // CPU bus cycle plus the reference register-file update
    task automatic cpu_bus(input logic c, input logic we, input logic [2:0] a,
                           input logic [1:0] dsn, input logic [15:0] d);
        @(negedge clk);
        cs = c; cpu_we = we; cpu_addr = a; cpu_dsn = dsn; cpu_dout = d;
        @(negedge clk);
        cs = 1'b0; cpu_we = 1'b0;
        if (c && we) begin
            if (m[5][2]) begin
                m[a] = d[7:0];
            end else begin
                if (!dsn[1]) m[{a[2:1], 1'b0}] = d[15:8];
                if (!dsn[0]) m[{a[2:1], 1'b1}] = d[7:0];
            end
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [1:0] dsn, input logic [15:0] d);
        cpu_bus(1'b1, 1'b1, a, dsn, d);
    endtask

    // Writes register 5 whatever the current bus mode is
    task automatic set_cfg(input logic [7:0] v);
        if (m[5][2]) cpu_wr(3'd5, 2'b11, {8'h00, v});
        else         cpu_wr(3'd4, 2'b10, {8'h00, v});
    endtask

    task automatic check_regs(input string tag);
        logic [2:0] sa;
        check({tag, ".xoffset"},   32'(xoffset),   32'({m[0][1:0], m[1]}));
        check({tag, ".yoffset"},   32'(yoffset),   32'({m[2][1:0], m[3]}));
        check({tag, ".cfg"},       32'(cfg),       32'(m[5]));
        check({tag, ".rmrd_addr"}, 32'(rmrd_addr), 32'({m[6][4:0], m[7], m[4]}));
        sa = 3'($urandom_range(0, 7));
        st_addr = sa;
        #1;
        check($sformatf("%s.st_dout[%0d]", tag, sa), 32'(st_dout), 32'(m[sa]));
    endtask

    task automatic scan_one(input string tag, input int a);
        @(negedge clk);
        scan_addr = 10'(a);
        @(negedge clk);
        check($sformatf("%s.even[%0d]", tag, a), 32'(scan_even), 32'(tbl[2 * a]));
        check($sformatf("%s.odd[%0d]", tag, a),  32'(scan_odd),  32'(tbl[2 * a + 1]));
    endtask

    task automatic scan_all(input string tag);
        for (int a = 0; a < 1024; a++) scan_one(tag, a);
    endtask

    task automatic fill_random_ext();
        for (int w = 0; w < 2048; w++) ext_ram[w] = 16'($urandom);
    endtask

    // vs low for two ticks, then a rising edge on the trigger tick
    task automatic start_dma(input string tag);
        vs = 1'b0;
        repeat (2) cen_tick();
        bsy_ticks = 0;
        vs = 1'b1;
        cen_tick();
        check({tag, ".bsy_rise"}, 32'(dma_bsy), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        for (int w = 0; w < 2048; w++) ext_ram[w] = 16'(w) ^ 16'hA5A5;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check("rst.dma_bsy",   32'(dma_bsy),   32'd0);
        check("rst.dma_addr",  32'(dma_addr),  32'd0);
        check("rst.cfg",       32'(cfg),       32'd0);
        check("rst.xoffset",   32'(xoffset),   32'd0);
        check("rst.yoffset",   32'(yoffset),   32'd0);
        check("rst.rmrd_addr", 32'(rmrd_addr), 32'd0);
        check("rst.st_dout",   32'(st_dout),   32'd0);
        rst_n = 1'b1;

        // ---------------- word-mode writes ----------------
        cpu_wr(3'd0, 2'b00, 16'h0123);
        check("word.xoffset", 32'(xoffset), 32'h123);
        cpu_wr(3'd4, 2'b10, 16'h00AB);   // word 2, odd byte only
        check("word.cfg", 32'(cfg), 32'hAB);
        st_addr = 3'd4;
        #1;
        check("word.mmr4_kept", 32'(st_dout), 32'h00);
        check_regs("word");

        // ---------------- byte-mode writes ----------------
        cpu_wr(3'd4, 2'b10, 16'h0004);
        check("byte.mode8", 32'(cfg), 32'h04);
        cpu_wr(3'd4, 2'b00, 16'hEE15);
        cpu_wr(3'd6, 2'b11, 16'hEE1F);   // strobes are ignored in byte mode
        cpu_wr(3'd7, 2'b01, 16'h0080);
        check("byte.rmrd_addr", 32'(rmrd_addr), 32'h1F_8015);
        check_regs("byte");

        // ---------------- debug readback ----------------
        cpu_wr(3'd5, 2'b00, 16'h0000);   // back to word mode
        cpu_wr(3'd2, 2'b00, 16'h02C0);
        st_addr = 3'd3;
        #1;
        check("dbg.st_dout", 32'(st_dout), 32'hC0);
        check("dbg.yoffset", 32'(yoffset), 32'h2C0);

        // ---------------- randomized register traffic ----------------
        for (int k = 0; k < 40; k++) begin
            cpu_bus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    3'($urandom), 2'($urandom), 16'($urandom));
            check_regs($sformatf("rnd%0d", k));
        end

        // ---------------- full DMA ----------------
        set_cfg(8'h10);
        start_dma("full");
        n = 0;
        while (dma_bsy && n < 3000) begin
            cen_tick();
            n++;
            if (n == 10) check("full.dma_addr_mid", 32'(dma_addr), 32'd9);
        end
        check("full.bsy_ticks", 32'(bsy_ticks), 32'd2049);
        check("full.dma_addr_end", 32'(dma_addr), 32'd0);
        vs = 1'b0;
        for (int w = 0; w < 2048; w++) tbl[w] = ext_ram[w];
        scan_addr = 10'h3FF;
        @(negedge clk);
        check("full.last_even", 32'(scan_even), 32'hA25B);
        check("full.last_odd",  32'(scan_odd),  32'hA25A);
        scan_addr = 10'h000;
        @(negedge clk);
        check("full.first_even", 32'(scan_even), 32'hA5A5);
        check("full.first_odd",  32'(scan_odd),  32'hA5A4);
        scan_all("full");

        // ---------------- DMA disabled ----------------
        fill_random_ext();
        set_cfg(8'h00);
        cen_tick();
        vs = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cen_tick();
            check($sformatf("off.bsy%0d", k), 32'(dma_bsy), 32'd0);
        end
        check("off.dma_addr", 32'(dma_addr), 32'd0);
        vs = 1'b0;
        for (int k = 0; k < 16; k++) scan_one("off", int'($urandom_range(0, 1023)));

        // ---------------- mid-transfer vs edge and dma_en clear ----------------
        fill_random_ext();
        set_cfg(8'h10);
        start_dma("mid");
        n = 0;
        while (dma_bsy && n < 3000) begin
            cen_tick();
            n++;
            if (n == 900) vs = 1'b0;
            if (n == 950) vs = 1'b1;       // new edge while dma_en is still set
            if (n == 1000) set_cfg(8'h00);
        end
        check("mid.bsy_ticks", 32'(bsy_ticks), 32'd2049);
        check("mid.cfg", 32'(cfg), 32'h00);
        repeat (4) cen_tick();
        check("mid.no_restart", 32'(dma_bsy), 32'd0);
        vs = 1'b0;
        for (int w = 0; w < 2048; w++) tbl[w] = ext_ram[w];
        scan_all("mid");

        // ---------------- reset during transfer ----------------
        fill_random_ext();
        set_cfg(8'h10);
        start_dma("rst");
        repeat (500) cen_tick();
        check("rst.dma_addr_pre", 32'(dma_addr), 32'd499);
        check("rst.bsy_pre", 32'(dma_bsy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstrun.dma_bsy",  32'(dma_bsy),  32'd0);
        check("rstrun.dma_addr", 32'(dma_addr), 32'd0);
        check("rstrun.cfg",      32'(cfg),      32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        for (int w = 0; w < 499; w++) tbl[w] = ext_ram[w];
        repeat (4) cen_tick();
        check("rstrun.idle", 32'(dma_bsy), 32'd0);
        vs = 1'b0;
        scan_all("rstrun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
